// File: rtl/sdram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : sdram_arbiter
// Description : Two-port (CPU / video) arbiter feeding the level-strobed,
//               ack-less SDRAM controller port with fixed hold and gap windows.
// Revision    : 1.0 - initial release
// ============================================================================
module sdram_arbiter #(
    parameter int WAIT_CYCLES = 12,
    parameter int GAP_CYCLES  = 3
) (
    input  logic        clk50mhz,
    input  logic        reset_n,
    input  logic [21:0] cpu_addr,
    input  logic [7:0]  cpu_wdata,
    input  logic        cpu_rd,
    input  logic        cpu_wr,
    output logic [7:0]  cpu_rdata,
    output logic        cpu_ready,
    input  logic [21:0] vid_addr,
    input  logic        vid_req,
    output logic [7:0]  vid_rdata,
    output logic        vid_ack,
    output logic [21:0] sd_addr,
    output logic [7:0]  sd_data,
    output logic        sd_rd,
    output logic        sd_we_n,
    input  logic [7:0]  sd_odata
);

    localparam int c_MAX_CNT = (WAIT_CYCLES > GAP_CYCLES) ? WAIT_CYCLES : GAP_CYCLES;
    localparam int c_CNT_W   = $clog2(c_MAX_CNT + 1);
    localparam logic [c_CNT_W-1:0] c_WAIT_LAST = c_CNT_W'(WAIT_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_GAP_LAST  = c_CNT_W'(GAP_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE   = c_CNT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DONE  = 2'd2,
        ST_GAP   = 2'd3
    } state_t;

    state_t               r_state;
    state_t               w_next_state;
    logic [c_CNT_W-1:0]   r_cnt;
    logic                 r_last_vid;
    logic                 r_gnt_vid;
    logic                 r_gnt_wr;
    logic                 w_cpu_req;
    logic                 w_grant;
    logic                 w_grant_vid;
    logic                 w_grant_wr;
    logic                 w_issue_end;
    logic                 w_cnt_run;

    assign w_cpu_req = cpu_rd | cpu_wr;

    always_ff @(posedge clk50mhz or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_cnt_run ? (r_cnt + c_CNT_ONE) : '0;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_grant      = 1'b0;
        w_grant_vid  = 1'b0;
        w_grant_wr   = 1'b0;
        w_issue_end  = 1'b0;
        w_cnt_run    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (vid_req || w_cpu_req) begin
                    w_grant      = 1'b1;
                    // Round-robin only matters under contention; a lone requester always wins.
                    w_grant_vid  = vid_req && (!w_cpu_req || !r_last_vid);
                    w_grant_wr   = !w_grant_vid && cpu_wr;
                    w_next_state = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (r_cnt == c_WAIT_LAST) begin
                    w_issue_end  = 1'b1;
                    w_next_state = ST_DONE;
                end else begin
                    w_cnt_run = 1'b1;
                end
            end
            ST_DONE: begin
                w_next_state = ST_GAP;
            end
            ST_GAP: begin
                if (r_cnt == c_GAP_LAST) begin
                    w_next_state = ST_IDLE;
                end else begin
                    w_cnt_run = 1'b1;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk50mhz or negedge reset_n) begin
        if (!reset_n) begin
            sd_addr    <= '0;
            sd_data    <= '0;
            sd_rd      <= 1'b0;
            sd_we_n    <= 1'b1;
            cpu_ready  <= 1'b0;
            vid_ack    <= 1'b0;
            cpu_rdata  <= '0;
            vid_rdata  <= '0;
            r_last_vid <= 1'b0;
            r_gnt_vid  <= 1'b0;
            r_gnt_wr   <= 1'b0;
        end else begin
            cpu_ready <= w_issue_end && !r_gnt_vid;
            vid_ack   <= w_issue_end && r_gnt_vid;
            if (w_grant) begin
                sd_addr    <= w_grant_vid ? vid_addr : cpu_addr;
                if (w_grant_wr) begin
                    sd_data <= cpu_wdata;
                end
                sd_rd      <= !w_grant_wr;
                sd_we_n    <= !w_grant_wr;
                r_gnt_vid  <= w_grant_vid;
                r_gnt_wr   <= w_grant_wr;
                r_last_vid <= w_grant_vid;
            end
            // Controller data is valid by the end of the worst-case window.
            if (w_issue_end) begin
                sd_rd   <= 1'b0;
                sd_we_n <= 1'b1;
                if (!r_gnt_wr) begin
                    if (r_gnt_vid) begin
                        vid_rdata <= sd_odata;
                    end else begin
                        cpu_rdata <= sd_odata;
                    end
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sdram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_sdram_arbiter
// Description : Self-checking bench for sdram_arbiter using a timeline model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sdram_arbiter;

    localparam int W = 12;
    localparam int G = 3;

    logic        clk50mhz  = 1'b0;
    logic        reset_n   = 1'b0;
    logic [21:0] cpu_addr  = '0;
    logic [7:0]  cpu_wdata = '0;
    logic        cpu_rd    = 1'b0;
    logic        cpu_wr    = 1'b0;
    logic [7:0]  cpu_rdata;
    logic        cpu_ready;
    logic [21:0] vid_addr  = '0;
    logic        vid_req   = 1'b0;
    logic [7:0]  vid_rdata;
    logic        vid_ack;
    logic [21:0] sd_addr;
    logic [7:0]  sd_data;
    logic        sd_rd;
    logic        sd_we_n;
    logic [7:0]  sd_odata  = '0;

    sdram_arbiter #(.WAIT_CYCLES(W), .GAP_CYCLES(G)) u_dut (
        .clk50mhz (clk50mhz),
        .reset_n  (reset_n),
        .cpu_addr (cpu_addr),
        .cpu_wdata(cpu_wdata),
        .cpu_rd   (cpu_rd),
        .cpu_wr   (cpu_wr),
        .cpu_rdata(cpu_rdata),
        .cpu_ready(cpu_ready),
        .vid_addr (vid_addr),
        .vid_req  (vid_req),
        .vid_rdata(vid_rdata),
        .vid_ack  (vid_ack),
        .sd_addr  (sd_addr),
        .sd_data  (sd_data),
        .sd_rd    (sd_rd),
        .sd_we_n  (sd_we_n),
        .sd_odata (sd_odata)
    );

    always #10 clk50mhz = ~clk50mhz;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Timeline model: an access granted in idle cycle g strobes g+1..g+W,
    // completes at g+W+1 and the arbiter is free again at g+W+2+G.
    int          k;
    int          g;
    int          free_at;
    bit          m_busy;
    bit          m_vid;
    bit          m_wr;
    bit          last_vid;
    logic [21:0] e_addr;
    logic [7:0]  e_data;
    logic [7:0]  e_crd;
    logic [7:0]  e_vrd;

    // Requester agents and controller data source
    bit          rnd;
    bit          hold_req;
    int          p_req;
    bit          cpu_pend;
    int          cpu_op;   // 0 read, 1 write, 2 read+write
    logic [21:0] cpu_a;
    logic [7:0]  cpu_d;
    bit          vid_pend;
    logic [21:0] vid_a;
    logic [7:0]  od;
    int          cpu_ready_at;
    int          vid_ack_at;
    int          n_cpu_done;
    int          n_vid_done;

    task automatic step();
        bit act;
        bit done;
        @(negedge clk50mhz);
        act  = m_busy && (k >= g + 1) && (k <= g + W);
        done = m_busy && (k == g + W + 1);
        chk("sd_rd",     sd_rd,     act && !m_wr);
        chk("sd_we_n",   sd_we_n,   !(act && m_wr));
        chk("cpu_ready", cpu_ready, done && !m_vid);
        chk("vid_ack",   vid_ack,   done && m_vid);
        chk("sd_addr",   sd_addr,   e_addr);
        chk("sd_data",   sd_data,   e_data);
        chk("cpu_rdata", cpu_rdata, e_crd);
        chk("vid_rdata", vid_rdata, e_vrd);
        if (cpu_ready) begin cpu_ready_at = k; n_cpu_done++; end
        if (vid_ack)   begin vid_ack_at   = k; n_vid_done++; end

        if (done && !hold_req) begin
            if (m_vid) vid_pend = 1'b0;
            else       cpu_pend = 1'b0;
        end
        if (rnd) begin
            if (!cpu_pend && $urandom_range(99) < p_req) begin
                cpu_pend = 1'b1;
                cpu_op   = $urandom_range(2);
                cpu_a    = 22'($urandom);
                cpu_d    = 8'($urandom);
            end
            if (!vid_pend && $urandom_range(99) < p_req) begin
                vid_pend = 1'b1;
                vid_a    = 22'($urandom);
            end
            od = 8'($urandom);
        end
        cpu_rd    = cpu_pend && (cpu_op != 1);
        cpu_wr    = cpu_pend && (cpu_op != 0);
        cpu_addr  = cpu_a;
        cpu_wdata = cpu_d;
        vid_req   = vid_pend;
        vid_addr  = vid_a;
        sd_odata  = od;

        if (m_busy && (k == g + W) && !m_wr) begin
            if (m_vid) e_vrd = od;
            else       e_crd = od;
        end
        if ((k >= free_at) && (vid_pend || cpu_pend)) begin
            m_vid    = vid_pend && (!cpu_pend || !last_vid);
            m_wr     = !m_vid && (cpu_op != 0);
            last_vid = m_vid;
            g        = k;
            free_at  = k + W + 2 + G;
            m_busy   = 1'b1;
            e_addr   = m_vid ? vid_a : cpu_a;
            if (m_wr) e_data = cpu_d;
        end
        k++;
    endtask

    task automatic do_reset(input int n);
        reset_n = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk50mhz);
            chk("rst_sd_rd",     sd_rd,     1'b0);
            chk("rst_sd_we_n",   sd_we_n,   1'b1);
            chk("rst_cpu_ready", cpu_ready, 1'b0);
            chk("rst_vid_ack",   vid_ack,   1'b0);
            chk("rst_sd_addr",   sd_addr,   22'h0);
            chk("rst_cpu_rdata", cpu_rdata, 8'h0);
            cpu_rd    = 1'($urandom);
            cpu_wr    = 1'($urandom);
            vid_req   = 1'($urandom);
            cpu_addr  = 22'($urandom);
            cpu_wdata = 8'($urandom);
            vid_addr  = 22'($urandom);
            sd_odata  = 8'($urandom);
        end
        @(negedge clk50mhz);
        k = 0; g = 0; free_at = 0; m_busy = 0; m_vid = 0; m_wr = 0; last_vid = 0;
        e_addr = '0; e_data = '0; e_crd = '0; e_vrd = '0;
        cpu_pend = 0; vid_pend = 0; cpu_op = 0; cpu_a = '0; cpu_d = '0; vid_a = '0; od = '0;
        cpu_ready_at = -1; vid_ack_at = -1; n_cpu_done = 0; n_vid_done = 0;
        cpu_rd = 0; cpu_wr = 0; vid_req = 0; cpu_addr = '0; cpu_wdata = '0;
        vid_addr = '0; sd_odata = '0;
        reset_n = 1'b1;
    endtask

    int t;

    initial begin
        rnd = 0; hold_req = 0; p_req = 30;
        do_reset(5);

        // CPU write
        cpu_pend = 1; cpu_op = 1; cpu_a = 22'h12345; cpu_d = 8'hA5;
        t = k;
        for (int i = 0; i < 20; i++) step();
        chk("wr_ready_cycle", cpu_ready_at, t + 13);
        chk("wr_rdata_kept", cpu_rdata, 8'h00);

        // CPU read, data held long after completion
        od = 8'h5A; cpu_pend = 1; cpu_op = 0; cpu_a = 22'h0ABCD;
        t = k;
        for (int i = 0; i < 20; i++) step();
        chk("rd_ready_cycle", cpu_ready_at, t + 13);
        od = 8'h00;
        for (int i = 0; i < 100; i++) step();
        chk("rd_rdata_held", cpu_rdata, 8'h5A);

        // Read and write both high: write wins
        cpu_pend = 1; cpu_op = 2; cpu_a = 22'h2AAAA; cpu_d = 8'h3C;
        for (int i = 0; i < 18; i++) step();
        chk("rdwr_sd_data", sd_data, 8'h3C);

        // Contention from reset, both held: video, CPU, video, CPU ...
        do_reset(2);
        hold_req = 1; od = 8'h77;
        cpu_pend = 1; cpu_op = 0; cpu_a = 22'h00111;
        vid_pend = 1; vid_a = 22'h3F222;
        t = k;
        for (int i = 0; i < 14; i++) step();
        chk("cont_vid_ack_cycle", vid_ack_at, t + 13);
        for (int i = 0; i < 17; i++) step();
        chk("cont_cpu_ready_cycle", cpu_ready_at, t + 30);
        for (int i = 0; i < 4 * (W + 2 + G); i++) step();
        chk("cont_vid_count", n_vid_done, 3);
        chk("cont_cpu_count", n_cpu_done, 3);
        hold_req = 0;

        // Asynchronous reset in the middle of a strobe window
        do_reset(2);
        cpu_pend = 1; cpu_op = 0; cpu_a = 22'h3FFFF; od = 8'hC3;
        for (int i = 0; i < 6; i++) step();
        #3;
        reset_n = 1'b0;
        #1;
        chk("async_sd_rd",   sd_rd,   1'b0);
        chk("async_sd_we_n", sd_we_n, 1'b1);
        chk("async_sd_addr", sd_addr, 22'h0);
        do_reset(2);

        // Randomized traffic with varying request density
        rnd = 1;
        for (int ph = 0; ph < 4; ph++) begin
            p_req = (ph == 0) ? 5 : (ph == 1) ? 30 : (ph == 2) ? 70 : 100;
            for (int i = 0; i < 800; i++) step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
